// File: rtl/irom_read_arbiter.sv
// Shares one IROM read port between IF and LS; grant is combinational, data returns RD_LATENCY clocks later.
// No response backpressure; fixed priority LS>IF with starvation guard, or round-robin when IROM_ARB_RR_EN is defined.
module irom_read_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  input  logic                  if_flush,
  output logic                  if_rvalid,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data
);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic                  w_ls_wins;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [RD_LATENCY-1:0] r_pipe_own;
  logic                  w_out_vld;
  logic                  w_out_own;

`ifdef IROM_ARB_RR_EN
  logic r_last_owner;

  assign w_ls_wins = (r_last_owner == OWN_IF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= OWN_IF;
    end else if (if_gnt) begin
      r_last_owner <= OWN_IF;
    end else if (ls_gnt) begin
      r_last_owner <= OWN_LS;
    end
  end
`else
  logic [3:0] r_starve_cnt;

  // IF only takes precedence once LS has won STARVE_LIMIT times in a row.
  assign w_ls_wins = (r_starve_cnt != 4'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (!if_req || if_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (ls_gnt && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif

  assign if_gnt = !rst && if_req && (!ls_req || !w_ls_wins);
  assign ls_gnt = !rst && ls_req && (!if_req || w_ls_wins);

  assign rom_addr = if_gnt ? if_addr : (ls_gnt ? ls_addr : r_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (if_gnt || ls_gnt) begin
      r_addr <= rom_addr;
    end
  end

  // Flush kills IF entries already in the pipe; this cycle's grant enters stage 0 untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      r_pipe_vld[0] <= if_gnt || ls_gnt;
      r_pipe_own[0] <= ls_gnt;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1] && !(if_flush && (r_pipe_own[k-1] == OWN_IF));
        r_pipe_own[k] <= r_pipe_own[k-1];
      end
    end
  end

  assign w_out_vld = r_pipe_vld[RD_LATENCY-1];
  assign w_out_own = r_pipe_own[RD_LATENCY-1];

  assign if_rvalid = w_out_vld && (w_out_own == OWN_IF) && !if_flush;
  assign ls_rvalid = w_out_vld && (w_out_own == OWN_LS);
  assign rd_data   = rom_rd_data;

endmodule
